// File: rtl/sensor_cond_if.sv
// Sensor/pushbutton signal bundle for sensor_cond.
// Glitch-count ports exist only when SENSOR_COND_GLITCH_CNT_EN is defined.
interface sensor_cond_if;
    logic       s2_raw;
    logic       s1_raw;
    logic       s0_raw;
    logic       p_raw;
    logic       S2;
    logic       S1;
    logic       S0;
    logic       P;
`ifdef SENSOR_COND_GLITCH_CNT_EN
    logic       glitch_clr;
    logic [7:0] glitch_cnt;
`endif

    modport master (
        output s2_raw, s1_raw, s0_raw, p_raw,
`ifdef SENSOR_COND_GLITCH_CNT_EN
        output glitch_clr,
        input  glitch_cnt,
`endif
        input  S2, S1, S0, P
    );

    modport slave (
        input  s2_raw, s1_raw, s0_raw, p_raw,
`ifdef SENSOR_COND_GLITCH_CNT_EN
        input  glitch_clr,
        output glitch_cnt,
`endif
        output S2, S1, S0, P
    );
endinterface

// File: rtl/sensor_cond.sv
// Synchronizes and debounces three level sensors and a start pushbutton.
// Optional aborted-transition counter enabled by SENSOR_COND_GLITCH_CNT_EN.
module sensor_cond #(
    parameter int unsigned DB_CYCLES = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    sensor_cond_if.slave if_sens
);
    localparam int unsigned NCH      = 4;
    localparam logic [15:0] DB_LIMIT = 16'(DB_CYCLES);

    // Channel index: 3 = s2, 2 = s1, 1 = s0, 0 = pushbutton
    logic [NCH-1:0] w_raw;
    logic [NCH-1:0] r_sync1;
    logic [NCH-1:0] r_sync2;
    logic [NCH-1:0] w_stable;
    logic           r_p_prev;
    logic           r_p;
`ifdef SENSOR_COND_GLITCH_CNT_EN
    logic [NCH-1:0] w_glitch;
    logic [7:0]     r_glitch_cnt;
`endif

    assign w_raw = {if_sens.s2_raw, if_sens.s1_raw, if_sens.s0_raw, if_sens.p_raw};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= w_raw;
            r_sync2 <= r_sync1;
        end
    end

    for (genvar g = 0; g < NCH; g++) begin : g_ch
        logic        r_stable;
        logic [15:0] r_cnt;
        logic [15:0] w_cnt_inc;

        assign w_cnt_inc = r_cnt + 16'd1;

        // Count is bounded below DB_LIMIT: it clears on acceptance, so it never wraps.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_stable <= 1'b0;
                r_cnt    <= '0;
            end else if (r_sync2[g] == r_stable) begin
                r_cnt <= '0;
            end else if (w_cnt_inc == DB_LIMIT) begin
                r_stable <= r_sync2[g];
                r_cnt    <= '0;
            end else begin
                r_cnt <= w_cnt_inc;
            end
        end

        assign w_stable[g] = r_stable;
`ifdef SENSOR_COND_GLITCH_CNT_EN
        assign w_glitch[g] = (r_cnt != '0) && (r_sync2[g] == r_stable);
`endif
    end

    // Start pulse follows the clock in which the debounced press is accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_p_prev <= 1'b0;
            r_p      <= 1'b0;
        end else begin
            r_p_prev <= w_stable[0];
            r_p      <= w_stable[0] & ~r_p_prev;
        end
    end

`ifdef SENSOR_COND_GLITCH_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_glitch_cnt <= '0;
        end else if (if_sens.glitch_clr) begin
            r_glitch_cnt <= '0;
        end else if ((|w_glitch) && (r_glitch_cnt != 8'hFF)) begin
            r_glitch_cnt <= r_glitch_cnt + 8'd1;
        end
    end

    assign if_sens.glitch_cnt = r_glitch_cnt;
`endif

    assign if_sens.S2 = w_stable[3];
    assign if_sens.S1 = w_stable[2];
    assign if_sens.S0 = w_stable[1];
    assign if_sens.P  = r_p;
endmodule
